pdh_cmd_ctrl: RTL
=================

# pdh_cmd_ctrl

Command sequencer between the PS GPIO command word and the PDH datapath configuration. It debounces the 32-bit command word and arms on a configuration command. On a subsequent STROBE it commits the pending command to the LED, module-enable and per-module configuration outputs, then waits for the PS to release the strobe. Status and a commit handshake are reported back on the GPIO return word.

## Interface
- CMD_BITS, 4, command field width, bits [31:28] of the input word
- DATA_BITS, 28, data field width, bits [27:0]
- NUM_MODULES, 4, number of downstream modules (1..16)
- TIMEOUT_CYCLES, 1024, maximum cycles spent in ARMED without a STROBE
- clk  in  1  system clock (FCLK_CLK0, 125 MHz)
- rst_n  in  1  reset, synchronous, active-low
- axi_from_ps_i  in  32  command word: cmd [31:28], data [27:0]
- axi_to_ps_o  out  32  status word (layout below)
- led_o  out  8  committed LED pattern
- en_bus_o  out  NUM_MODULES  committed module-enable mask
- cfg_data_o  out  24  committed configuration value
- cfg_wr_o  out  NUM_MODULES  one-hot, one-cycle write strobe to the addressed module

## Operation
- Commands:
  - 0x0 IDLE
  - 0x1 SET_LED: data[7:0]
  - 0x2 ENABLE: data[NUM_MODULES-1:0]
  - 0x3 WRITE_CFG: module index in data[27:24], value in data[23:0]
  - 0xE STROBE
  - All other codes are invalid.
- Input registered twice (in_r, in_rr). The word is "stable" when in_r == in_rr. FSM acts only on stable words.
- States and codes: S_IDLE=0, S_ARMED=1, S_COMMIT=2, S_ACK=3, S_ERROR=4.
- S_IDLE:
  - Stable 0x1/0x2/0x3 → latch cmd+data into pending, go to S_ARMED.
  - Stable STROBE → ignored.
  - Stable invalid code → S_ERROR.
  - WRITE_CFG with index ≥ NUM_MODULES → S_ERROR.
- S_ARMED:
  - Stable arm command different from pending → re-latch, restart timeout counter.
  - Stable STROBE → S_COMMIT.
  - Stable IDLE → S_IDLE, pending discarded.
  - Stable invalid code → S_ERROR.
  - Timeout expiry → S_IDLE, set err_timeout.
  - STROBE and timeout in the same cycle → STROBE wins.
- S_COMMIT (exactly 1 cycle):
  - Apply pending: SET_LED → led_o; ENABLE → en_bus_o; WRITE_CFG → cfg_data_o plus cfg_wr_o[index].
  - Increment commit_cnt (8-bit, wraps 255→0). Clear both sticky errors. Record last_cmd. Go to S_ACK.
- S_ACK: remain while stable word has cmd==STROBE. Any other stable word → S_IDLE. A held strobe never commits twice.
- S_ERROR: set err_invalid (sticky). Leave to S_IDLE only on stable IDLE.
- Status word axi_to_ps_o:
  - [31:28] state code
  - [27] err_invalid
  - [26] err_timeout
  - [25] busy (ARMED or COMMIT)
  - [24] ack (S_ACK)
  - [23:16] commit_cnt
  - [15:12] last_cmd
  - [11:0] committed data[11:0]

## Timing
- Reset: all outputs 0, state S_IDLE, pending, counters and sticky flags cleared. Reset mid-operation discards pending with no cfg_wr_o pulse.
- Word changes before edge k: in_r updates at k, stable at k+1, FSM transition at edge k+2.
- STROBE word before edge k: S_COMMIT from edge k+2. Committed outputs and cfg_wr_o updated at edge k+3. cfg_wr_o is high for exactly the cycle between k+3 and k+4.
- Timeout counter starts at 0 on entering or re-latching ARMED. Expiry is at count TIMEOUT_CYCLES-1.
- All outputs registered; axi_to_ps_o reflects state one cycle after the state register.

## Configuration
- PDH_CMD_TIMEOUT_EN defined: ARMED timeout active as above.
- Not defined: no timeout counter; ARMED waits indefinitely; status bit 26 is constant 0.

## Test plan
- Reset with input 0xE0000000 → axi_to_ps_o=0, all outputs 0, no cfg_wr_o pulse.
- 0x100000A5, then 0xE0000000 → led_o=0xA5, commit_cnt=1, status[24]=1. Then 0x00000000 → state 0.
- 0x32123456, then STROBE → cfg_data_o=0x123456, cfg_wr_o=4'b0100 for 1 cycle, 3 edges after STROBE. Holding STROBE 100 cycles → no second pulse.
- 0x35000001 → S_ERROR, status[27]=1. STROBE → no commit. 0x0, then 0x2000000F, then STROBE → en_bus_o=4'hF, status[27]=0.
- 0x100000FF held 1030 cycles (macro defined) → S_IDLE, status[26]=1, led_o unchanged. Macro undefined → still ARMED.
- 256 ENABLE/STROBE/IDLE cycles → commit_cnt wraps to 0x00. A single-cycle glitch word 0xF0000000 → ignored (not stable).

Source files
------------

// File: rtl/pdh_cmd_ctrl_if.sv
// pdh_cmd_ctrl_if: PS GPIO command/status bus plus the committed configuration outputs of
// pdh_cmd_ctrl, bundled into one interface.
//   axi_from_ps_i : 32-bit command word from the PS (cmd [31:28], data [27:0])
//   axi_to_ps_o   : 32-bit status word back to the PS
//   led_o         : committed LED pattern
//   en_bus_o      : committed module-enable mask
//   cfg_data_o    : committed configuration value
//   cfg_wr_o      : one-hot, single-cycle write strobe to the addressed module
// The master modport is the PS / stimulus side; the slave modport is the controller.
interface pdh_cmd_ctrl_if #(
  parameter int unsigned NUM_MODULES = 4
);
  logic [31:0]            axi_from_ps_i;
  logic [31:0]            axi_to_ps_o;
  logic [7:0]             led_o;
  logic [NUM_MODULES-1:0] en_bus_o;
  logic [23:0]            cfg_data_o;
  logic [NUM_MODULES-1:0] cfg_wr_o;

  modport master (
    output axi_from_ps_i,
    input  axi_to_ps_o,
    input  led_o,
    input  en_bus_o,
    input  cfg_data_o,
    input  cfg_wr_o
  );

  modport slave (
    input  axi_from_ps_i,
    output axi_to_ps_o,
    output led_o,
    output en_bus_o,
    output cfg_data_o,
    output cfg_wr_o
  );
endinterface

// File: rtl/pdh_cmd_ctrl.sv
// pdh_cmd_ctrl: command sequencer between the PS GPIO command word and the PDH datapath
// configuration. A configuration command (SET_LED / ENABLE / WRITE_CFG) arms the sequencer;
// a following STROBE commits it to the outputs for one cycle, after which the sequencer waits
// for the PS to drop the strobe. Status and a commit handshake go back on axi_to_ps_o.
// Ports:
//   clk   : system clock
//   rst_n : synchronous, active-low reset
//   bus   : pdh_cmd_ctrl_if slave modport (command word in, status word and committed
//           LED / enable / config / write-strobe outputs out, all registered)
// Build option: define PDH_CMD_TIMEOUT_EN to abandon ARMED after TIMEOUT_CYCLES cycles
// without a STROBE (sets err_timeout, status bit 26). Without it ARMED waits indefinitely
// and bit 26 reads 0.
module pdh_cmd_ctrl #(
  parameter int unsigned CMD_BITS       = 4,
  parameter int unsigned DATA_BITS      = 28,
  parameter int unsigned NUM_MODULES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst_n,
  pdh_cmd_ctrl_if.slave bus
);

  localparam int unsigned WordW = CMD_BITS + DATA_BITS;

  localparam logic [CMD_BITS-1:0] CmdIdle   = CMD_BITS'(4'h0);
  localparam logic [CMD_BITS-1:0] CmdSetLed = CMD_BITS'(4'h1);
  localparam logic [CMD_BITS-1:0] CmdEnable = CMD_BITS'(4'h2);
  localparam logic [CMD_BITS-1:0] CmdWrCfg  = CMD_BITS'(4'h3);
  localparam logic [CMD_BITS-1:0] CmdStrobe = CMD_BITS'(4'hE);

  // Encodings double as the status-word state code.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StArmed  = 4'd1,
    StCommit = 4'd2,
    StAck    = 4'd3,
    StError  = 4'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [WordW-1:0]       in_r_q, in_rr_q;
  logic [CMD_BITS-1:0]    pend_cmd_q, pend_cmd_d;
  logic [DATA_BITS-1:0]   pend_data_q, pend_data_d;
  logic [7:0]             led_q, led_d;
  logic [NUM_MODULES-1:0] en_q, en_d;
  logic [23:0]            cfg_data_q, cfg_data_d;
  logic [NUM_MODULES-1:0] cfg_wr_q, cfg_wr_d;
  logic [7:0]             commit_cnt_q, commit_cnt_d;
  logic [CMD_BITS-1:0]    last_cmd_q, last_cmd_d;
  logic [11:0]            commit_data_q, commit_data_d;
  logic                   err_inv_q, err_inv_d;
  logic                   err_to;
  logic [31:0]            status_q, status_d;

  // Decode of the settled input word.
  logic                 stable;
  logic [CMD_BITS-1:0]  word_cmd;
  logic [DATA_BITS-1:0] word_data;
  logic [3:0]           word_idx;
  logic [3:0]           pend_idx;
  logic                 is_arm;
  logic                 is_valid;
  logic                 bad_index;
  logic                 goes_error;
  logic                 differs_pend;

  assign stable       = (in_r_q == in_rr_q);
  assign word_cmd     = in_rr_q[WordW-1 -: CMD_BITS];
  assign word_data    = in_rr_q[DATA_BITS-1:0];
  assign word_idx     = word_data[DATA_BITS-1 -: 4];
  assign pend_idx     = pend_data_q[DATA_BITS-1 -: 4];
  assign is_arm       = (word_cmd == CmdSetLed) || (word_cmd == CmdEnable) ||
                        (word_cmd == CmdWrCfg);
  assign is_valid     = is_arm || (word_cmd == CmdIdle) || (word_cmd == CmdStrobe);
  assign bad_index    = (word_cmd == CmdWrCfg) && ({1'b0, word_idx} >= 5'(NUM_MODULES));
  assign goes_error   = !is_valid || bad_index;
  assign differs_pend = (in_rr_q != {pend_cmd_q, pend_data_q});

`ifdef PDH_CMD_TIMEOUT_EN
  localparam int unsigned  TcW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TcW-1:0] TcMax = TcW'(TIMEOUT_CYCLES - 1);

  logic [TcW-1:0] tcnt_q, tcnt_d;
  logic           err_to_q, err_to_d;
  // After a timeout the still-present arm word would re-arm at once; hold off re-arming
  // until the PS changes the word.
  logic           block_q, block_d;

  assign err_to = err_to_q;
`else
  assign err_to = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pend_cmd_d    = pend_cmd_q;
    pend_data_d   = pend_data_q;
    led_d         = led_q;
    en_d          = en_q;
    cfg_data_d    = cfg_data_q;
    cfg_wr_d      = '0;
    commit_cnt_d  = commit_cnt_q;
    last_cmd_d    = last_cmd_q;
    commit_data_d = commit_data_q;
    err_inv_d     = err_inv_q;
`ifdef PDH_CMD_TIMEOUT_EN
    tcnt_d        = tcnt_q;
    err_to_d      = err_to_q;
    block_d       = block_q;
    if (block_q && stable && differs_pend) begin
      block_d = 1'b0;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (stable) begin
          if (goes_error) begin
            state_d = StError;
          end else if (is_arm
`ifdef PDH_CMD_TIMEOUT_EN
                       && !(block_q && !differs_pend)
`endif
                      ) begin
            pend_cmd_d  = word_cmd;
            pend_data_d = word_data;
            state_d     = StArmed;
`ifdef PDH_CMD_TIMEOUT_EN
            tcnt_d      = '0;
            block_d     = 1'b0;
`endif
          end
        end
      end

      StArmed: begin
        // STROBE is tested first so it beats a coincident timeout.
        if (stable && (word_cmd == CmdStrobe)) begin
          state_d = StCommit;
        end else if (stable && goes_error) begin
          state_d = StError;
        end else if (stable && (word_cmd == CmdIdle)) begin
          state_d     = StIdle;
          pend_cmd_d  = '0;
          pend_data_d = '0;
        end else if (stable && is_arm && differs_pend) begin
          pend_cmd_d  = word_cmd;
          pend_data_d = word_data;
`ifdef PDH_CMD_TIMEOUT_EN
          tcnt_d      = '0;
`endif
        end
`ifdef PDH_CMD_TIMEOUT_EN
        else if (tcnt_q == TcMax) begin
          state_d  = StIdle;
          err_to_d = 1'b1;
          block_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TcW'(1);
        end
`endif
      end

      StCommit: begin
        case (pend_cmd_q)
          CmdSetLed: led_d = pend_data_q[7:0];
          CmdEnable: en_d  = pend_data_q[NUM_MODULES-1:0];
          CmdWrCfg: begin
            cfg_data_d = pend_data_q[23:0];
            cfg_wr_d   = NUM_MODULES'(1) << pend_idx;
          end
          default: ;
        endcase
        commit_cnt_d  = commit_cnt_q + 8'd1;
        last_cmd_d    = pend_cmd_q;
        commit_data_d = pend_data_q[11:0];
        err_inv_d     = 1'b0;
`ifdef PDH_CMD_TIMEOUT_EN
        err_to_d      = 1'b0;
`endif
        state_d       = StAck;
      end

      StAck: begin
        if (stable && (word_cmd != CmdStrobe)) begin
          state_d = StIdle;
        end
      end

      StError: begin
        if (stable && (word_cmd == CmdIdle)) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Flag is raised on the edge that enters ERROR and held while there.
    if (state_d == StError) begin
      err_inv_d = 1'b1;
    end

    status_d = {state_q, err_inv_q, err_to,
                (state_q == StArmed) || (state_q == StCommit), (state_q == StAck),
                commit_cnt_q, last_cmd_q, commit_data_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      in_r_q        <= '0;
      in_rr_q       <= '0;
      pend_cmd_q    <= '0;
      pend_data_q   <= '0;
      led_q         <= '0;
      en_q          <= '0;
      cfg_data_q    <= '0;
      cfg_wr_q      <= '0;
      commit_cnt_q  <= '0;
      last_cmd_q    <= '0;
      commit_data_q <= '0;
      err_inv_q     <= 1'b0;
      status_q      <= '0;
`ifdef PDH_CMD_TIMEOUT_EN
      tcnt_q        <= '0;
      err_to_q      <= 1'b0;
      block_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      in_r_q        <= bus.axi_from_ps_i;
      in_rr_q       <= in_r_q;
      pend_cmd_q    <= pend_cmd_d;
      pend_data_q   <= pend_data_d;
      led_q         <= led_d;
      en_q          <= en_d;
      cfg_data_q    <= cfg_data_d;
      cfg_wr_q      <= cfg_wr_d;
      commit_cnt_q  <= commit_cnt_d;
      last_cmd_q    <= last_cmd_d;
      commit_data_q <= commit_data_d;
      err_inv_q     <= err_inv_d;
      status_q      <= status_d;
`ifdef PDH_CMD_TIMEOUT_EN
      tcnt_q        <= tcnt_d;
      err_to_q      <= err_to_d;
      block_q       <= block_d;
`endif
    end
  end

  assign bus.axi_to_ps_o = status_q;
  assign bus.led_o       = led_q;
  assign bus.en_bus_o    = en_q;
  assign bus.cfg_data_o  = cfg_data_q;
  assign bus.cfg_wr_o    = cfg_wr_q;

endmodule
